// File: rtl/riscv_pkg.sv
// Shared RV32 opcode constants and hazard-sequencer state encoding.
// Also used by the immediate generator, control unit and forwarding unit.
package riscv_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;

  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_src_decode.sv
// Maps an opcode to the source registers it actually reads.
// Kept separate so the forwarding unit can reuse it.
module hazard_src_decode
  import riscv_pkg::*;
(
  input  logic [6:0] op_i,
  output logic       uses_rs1_o,
  output logic       uses_rs2_o
);

  always_comb begin
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    case (op_i)
      OP_RTYPE, OP_STORE, OP_BRANCH: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
      end
      OP_ITYPE, OP_LOAD, OP_JALR: uses_rs1_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Schedules IF/ID and ID/EX around load-use hazards, EX redirects and memory stalls.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_sequencer
  import riscv_pkg::*;
#(
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       id_op_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             ex_mem_read_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_redirect_i,
  input  logic             mem_stall_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             hz_state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  if (LOAD_USE_STALLS < 1 || LOAD_USE_STALLS > 7) begin : g_bad_param
    $error("LOAD_USE_STALLS must be in 1..7");
  end

  hz_state_e  state_q, state_d;
  logic [2:0] bub_cnt_q, bub_cnt_d;
  logic       uses_rs1, uses_rs2;
  logic       lu_hit;

  hazard_src_decode u_src_decode (
    .op_i       (id_op_i),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );

  assign lu_hit = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  ((uses_rs1 && (id_rs1_i == ex_rd_i)) ||
                   (uses_rs2 && (id_rs2_i == ex_rd_i)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= HZ_RUN;
      bub_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      bub_cnt_q <= bub_cnt_d;
    end
  end

  // A redirect out of LU_STALL is a protocol violation; recover to a clean RUN.
  always_comb begin
    state_d   = state_q;
    bub_cnt_d = bub_cnt_q;
    if (!mem_stall_i) begin
      if (ex_redirect_i) begin
        state_d   = HZ_RUN;
        bub_cnt_d = 3'd0;
      end else if (state_q == HZ_LU_STALL) begin
        if (bub_cnt_q == 3'd1) begin
          state_d   = HZ_RUN;
          bub_cnt_d = 3'd0;
        end else begin
          bub_cnt_d = bub_cnt_q - 3'd1;
        end
      end else if (lu_hit && (LOAD_USE_STALLS > 1)) begin
        state_d   = HZ_LU_STALL;
        bub_cnt_d = 3'(LOAD_USE_STALLS - 1);
      end
    end
  end

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_flush_o = 1'b0;
    if (!reset) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if (mem_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
    end else if (ex_redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
    end else if ((state_q == HZ_LU_STALL) || lu_hit) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
    end
  end

  assign hz_state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  assign stall_evt = !mem_stall_i && !ex_redirect_i && ((state_q == HZ_LU_STALL) || lu_hit);
  assign flush_evt = !mem_stall_i && ex_redirect_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_evt && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block that schedules the IF/ID and ID/EX stage registers around the decode stage, where the immediate constant is built.
- Detects load-use hazards from the ID instruction's opcode and source registers, and inserts a parameterisable number of bubbles with a small state machine.
- Flushes the younger stages on EX-resolved redirects (taken branch, JAL, JALR).
- Freezes everything on a memory stall.

Parameters:
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- id_op_i  input  7  opcode of the instruction in ID.
- id_rs1_i  input  5  rs1 field of the ID instruction.
- id_rs2_i  input  5  rs2 field of the ID instruction.
- ex_mem_read_i  input  1  instruction in EX is a load.
- ex_rd_i  input  5  destination register of the instruction in EX.
- ex_redirect_i  input  1  EX resolved a taken branch, JAL or JALR this cycle.
- mem_stall_i  input  1  data/instruction memory not ready; freeze the pipeline.
- pc_write_o  output  1  PC register enable.
- if_id_write_o  output  1  IF/ID register enable.
- if_id_flush_o  output  1  load NOP into IF/ID.
- id_ex_flush_o  output  1  load bubble into ID/EX.
- hz_state_o  output  1  current FSM state (0=RUN, 1=LU_STALL).
- stall_cnt_o  output  CNT_W  load-use bubble count (optional feature).
- flush_cnt_o  output  CNT_W  redirect count (optional feature).

Behaviour:
- Register use by ID opcode:
  - Uses rs1: opcodes 0x33, 0x13, 0x03, 0x23, 0x63, 0x67.
  - Uses rs2: opcodes 0x33, 0x23, 0x63.
  - Uses neither: 0x37, 0x6F, and any unlisted opcode.
- Load-use detect (lu_hit), combinational: ex_mem_read_i & ex_rd_i!=0 & ((uses_rs1 & id_rs1_i==ex_rd_i) | (uses_rs2 & id_rs2_i==ex_rd_i)).
- Registered state: FSM state plus a 3-bit bubble counter bub_cnt. Outputs are combinational from state and inputs.
- Priority, highest first: reset, then mem_stall_i, then ex_redirect_i, then lu_hit / LU_STALL hold, then normal.
- Reset (reset low, async):
  - state=RUN, bub_cnt=0, counters=0.
  - While reset is low: pc_write_o=0, if_id_write_o=0, if_id_flush_o=1, id_ex_flush_o=1.
- mem_stall_i=1, any state:
  - pc_write_o=0, if_id_write_o=0, both flushes 0.
  - State, bub_cnt and counters hold.
  - A pending redirect or hazard is re-evaluated once the stall drops; upstream holds its inputs stable.
- RUN, normal: pc_write_o=1, if_id_write_o=1, flushes 0.
- RUN, ex_redirect_i=1:
  - pc_write_o=1 (target load), if_id_write_o=1, if_id_flush_o=1, id_ex_flush_o=1.
  - Stay in RUN; flush_cnt +1.
  - lu_hit in the same cycle is ignored, since the ID instruction is being flushed.
- RUN, lu_hit=1, no redirect:
  - pc_write_o=0, if_id_write_o=0, id_ex_flush_o=1; stall_cnt +1.
  - If LOAD_USE_STALLS==1: stay in RUN.
  - Else: go to LU_STALL with bub_cnt=LOAD_USE_STALLS-1.
- LU_STALL:
  - Outputs as a RUN lu_hit cycle (PC and IF/ID held, bubble into ID/EX); stall_cnt +1 per cycle.
  - bub_cnt decrements each cycle.
  - When bub_cnt==1 in the current cycle: next state RUN, bub_cnt 0.
  - Net stall is exactly LOAD_USE_STALLS cycles per hazard.
- LU_STALL with ex_redirect_i=1: protocol violation (EX holds only bubbles). Required recovery: apply RUN redirect outputs, go to RUN, clear bub_cnt.
- Back-to-back loads: a new lu_hit on the first RUN cycle after LU_STALL starts a fresh stall.
- Counters are saturating at all-ones; no wrap.
- Reset asserted mid-stall aborts it immediately, with no residual bubble after release.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cnt_o and flush_cnt_o are CNT_W-bit saturating counters as above.
- Undefined: both ports remain and are tied to 0; no counter flops are synthesised.

Decomposition:
- Shared package riscv_pkg:
  - Opcode constants OP_RTYPE=7'h33, OP_ITYPE=7'h13, OP_LOAD=7'h03, OP_STORE=7'h23, OP_BRANCH=7'h63, OP_JALR=7'h67, OP_JAL=7'h6F, OP_LUI=7'h37. These are shared with the immediate generator and the control unit.
  - State encoding constants HZ_RUN=1'b0, HZ_LU_STALL=1'b1.
- Sub-module hazard_src_decode: combinational opcode to {uses_rs1, uses_rs2}. It is reusable by the forwarding unit.

Test Plan:
- Reset release with no hazards (op=0x33, no load in EX) -> pc_write_o=1, if_id_write_o=1, flushes 0, hz_state_o=0 on the first post-reset cycle.
- LOAD_USE_STALLS=1: ex_mem_read_i=1, ex_rd_i=5, id_op=0x33, id_rs2=5 -> one cycle of pc_write_o=0 and id_ex_flush_o=1, then normal; stall_cnt_o=1.
- LOAD_USE_STALLS=3: same hazard with id_op=0x23 on rs1 -> exactly 3 stall cycles, hz_state_o=1 for cycles 2-3; ex_rd_i=0 or id_op=0x37 with a matching field -> no stall.
- ex_redirect_i=1 concurrent with lu_hit -> both flushes 1, pc_write_o=1, no stall; flush_cnt_o=1, stall_cnt_o=0.
- mem_stall_i=1 for 4 cycles mid LU_STALL (bub_cnt=2) -> all enables 0, state and bub_cnt frozen; stall completes with the remaining cycles after release.
- reset pulled low in the middle of LU_STALL -> immediate RUN, counters 0; with HAZARD_PERF_EN undefined, the counters read 0 throughout.
